tlb_unit: RTL and testbench
===========================

Name: tlb_unit

Overview:
- Translation lookaside buffer that sits directly upstream of the per-port address translators.
- Holds TLBNUM entries with 4KB even/odd page pairs.
- Serves two combinational search ports, one for fetch and one for load/store, each returning the tlb_result_t the translators consume.
- Executes TLBWR/TLBFILL writes, TLBRD reads, and INVTLB. INVTLB is a multi-cycle sweep FSM that stalls the pipeline through busy.

Parameters:
- TLBNUM, 16, number of entries (power of 2).
- IDX_W, $clog2(TLBNUM), index width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- s0_vppn  in  19  fetch-port VA[31:13]
- s0_va_bit12  in  1  fetch-port VA[12], odd/even page select
- s0_asid  in  10  fetch-port ASID
- s0_result  out  tlb_result_t  {found, index[IDX_W], ppn[20], mat[2], plv[2], d, v}
- s1_vppn, s1_va_bit12, s1_asid, s1_result  same as port 0, load/store port
- we  in  1  write strobe (TLBWR/TLBFILL)
- w_index  in  IDX_W  write index
- w_e, w_vppn[19], w_asid[10], w_g  in  entry tag fields
- w_ppn0[20], w_plv0[2], w_mat0[2], w_d0, w_v0  in  even page fields
- w_ppn1[20], w_plv1[2], w_mat1[2], w_d1, w_v1  in  odd page fields
- r_index  in  IDX_W  read index (TLBRD)
- r_*  out  same fields as w_*  combinational read of entry r_index
- fill_index  out  IDX_W  pseudo-random TLBFILL index
- inv_valid  in  1  INVTLB request
- inv_op  in  5  INVTLB op
- inv_asid  in  10  INVTLB ASID operand
- inv_vppn  in  19  INVTLB VA[31:13] operand
- busy  out  1  sweep in progress; pipeline must stall
- inv_done  out  1  one-cycle pulse when sweep completes
- inv_op_err  out  1  one-cycle pulse for illegal op

Behaviour:
- Reset (resetn=0 at posedge):
  - All entry fields cleared to 0, so every e=0.
  - FSM returns to IDLE; busy=0, inv_done=0, inv_op_err=0.
  - Random counter set to 0.
  - Reset mid-sweep aborts the sweep; no further entries are cleared.
- Search (combinational, both ports independent):
  - Hit on entry i requires e=1 && vppn==s_vppn && (g || asid==s_asid).
  - found = any hit; index = lowest hitting i. Multiple hits are a software error; lowest index wins deterministically.
  - Page fields come from odd page if va_bit12=1, else even page.
  - On miss, all result fields are 0.
  - Search sees the array as of the current cycle. A write at edge N is visible from cycle N+1.
- Write:
  - When we=1 and state==IDLE, entry w_index takes all w_* fields at posedge.
  - we while busy is ignored. The pipeline guarantees this does not happen; assert in simulation.
- Read: r_* = entry[r_index], combinational.
- fill_index: free-running IDX_W-bit counter, +1 every cycle, wraps TLBNUM-1 -> 0.
- INVTLB FSM, states IDLE, SWEEP:
  - IDLE + inv_valid, inv_op <= 6: latch op/asid/vppn, ptr=0, go to SWEEP, busy=1 from the next cycle.
  - IDLE + inv_valid, inv_op > 6: inv_op_err pulses next cycle, stay IDLE, array unchanged.
  - SWEEP: each cycle evaluate entry[ptr] and clear its e if it matches; ptr++.
  - When ptr==TLBNUM-1 is processed: go to IDLE, inv_done pulses that same edge, busy=0.
  - Sweep latency is TLBNUM cycles from accept to inv_done.
  - Match rules (G=g, A=asid==op_asid, V=vppn==op_vppn):
    - op 0,1: all entries
    - op 2: G=1
    - op 3: G=0
    - op 4: G=0 && A
    - op 5: G=0 && A && V
    - op 6: (G=1 || A) && V
  - inv_valid while busy is ignored.
  - A we in the same cycle as an accepted inv_valid is performed; the write precedes the sweep's visit of that entry.

Test Plan:
- Write idx 3 {e=1,vppn=0x12345,asid=5,g=0,ppn0=0xAAAAA,v0=1,ppn1=0xBBBBB,d1=1}. Search port0 vppn=0x12345, bit12=1, asid=5 -> found=1, index=3, ppn=0xBBBBB, d=1. Same search with asid=6 -> found=0, all fields 0.
- Entry 3 as above, then entry 7 with the same vppn and g=1. Search with asid=5 -> index=3. Read r_index=7 -> r_g=1.
- Fill all 16 entries with e=1, g alternating, asid=5. inv_op=3 -> busy high for 16 cycles, inv_done pulse. Afterwards only odd g=1 entries still hit.
- inv_op=5, asid=5, vppn matching entry 3 only -> entry 3 e=0, all others unchanged. inv_op=7 -> inv_op_err pulse, busy stays 0.
- Pull resetn low at sweep cycle 4 -> next cycle busy=0, no inv_done, all e=0, fill_index=0.
- Sample fill_index over 20 cycles after reset -> sequence 1..15, 0, 1..4.

Source files
------------

// File: rtl/tlb_unit.sv
// tlb_unit: translation lookaside buffer with TLBNUM entries, each mapping a
// 4KB even/odd page pair. It feeds the fetch and load/store address
// translators.
//
// Ports
//   clk, resetn                  clock and synchronous active-low reset
//   s0_* / s1_*                  fetch / load-store search: vppn, va_bit12, asid in,
//                                result out as {found, index, ppn, mat, plv, d, v}
//   we, w_index, w_*             TLBWR/TLBFILL entry write
//   r_index, r_*                 TLBRD combinational read of one entry
//   fill_index                   free-running pseudo-random TLBFILL index
//   inv_valid, inv_op,
//   inv_asid, inv_vppn           INVTLB request and its operands
//   busy                         invalidation sweep running; the pipeline must stall
//   inv_done                     one-cycle pulse when the sweep completes
//   inv_op_err                   one-cycle pulse when the INVTLB op is illegal
//
// Sweep FSM
//   state    | meaning
//   ST_IDLE  | accepts writes and INVTLB requests
//   ST_SWEEP | visits one entry per cycle and clears e on a match

module tlb_unit #(
    parameter int TLBNUM = 16,
    parameter int IDX_W  = $clog2(TLBNUM)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [18:0]       s0_vppn,
    input  logic              s0_va_bit12,
    input  logic [9:0]        s0_asid,
    output logic [IDX_W+26:0] s0_result,
    input  logic [18:0]       s1_vppn,
    input  logic              s1_va_bit12,
    input  logic [9:0]        s1_asid,
    output logic [IDX_W+26:0] s1_result,
    input  logic              we,
    input  logic [IDX_W-1:0]  w_index,
    input  logic              w_e,
    input  logic [18:0]       w_vppn,
    input  logic [9:0]        w_asid,
    input  logic              w_g,
    input  logic [19:0]       w_ppn0,
    input  logic [1:0]        w_plv0,
    input  logic [1:0]        w_mat0,
    input  logic              w_d0,
    input  logic              w_v0,
    input  logic [19:0]       w_ppn1,
    input  logic [1:0]        w_plv1,
    input  logic [1:0]        w_mat1,
    input  logic              w_d1,
    input  logic              w_v1,
    input  logic [IDX_W-1:0]  r_index,
    output logic              r_e,
    output logic [18:0]       r_vppn,
    output logic [9:0]        r_asid,
    output logic              r_g,
    output logic [19:0]       r_ppn0,
    output logic [1:0]        r_plv0,
    output logic [1:0]        r_mat0,
    output logic              r_d0,
    output logic              r_v0,
    output logic [19:0]       r_ppn1,
    output logic [1:0]        r_plv1,
    output logic [1:0]        r_mat1,
    output logic              r_d1,
    output logic              r_v1,
    output logic [IDX_W-1:0]  fill_index,
    input  logic              inv_valid,
    input  logic [4:0]        inv_op,
    input  logic [9:0]        inv_asid,
    input  logic [18:0]       inv_vppn,
    output logic              busy,
    output logic              inv_done,
    output logic              inv_op_err
);

    typedef enum logic {ST_IDLE, ST_SWEEP} state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLBNUM - 1);

    // entry array
    logic        e_q    [TLBNUM];
    logic [18:0] vppn_q [TLBNUM];
    logic [9:0]  asid_q [TLBNUM];
    logic        g_q    [TLBNUM];
    logic [19:0] ppn0_q [TLBNUM];
    logic [1:0]  plv0_q [TLBNUM];
    logic [1:0]  mat0_q [TLBNUM];
    logic        d0_q   [TLBNUM];
    logic        v0_q   [TLBNUM];
    logic [19:0] ppn1_q [TLBNUM];
    logic [1:0]  plv1_q [TLBNUM];
    logic [1:0]  mat1_q [TLBNUM];
    logic        d1_q   [TLBNUM];
    logic        v1_q   [TLBNUM];

    // sweep FSM and counters
    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [2:0]       op_q, op_d;
    logic [9:0]       op_asid_q, op_asid_d;
    logic [18:0]      op_vppn_q, op_vppn_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] fill_q;

    logic             wr_en;
    logic             sweep_match;
    logic             sweep_clr;

    // search ports
    logic [18:0]       s_vppn  [2];
    logic              s_bit12 [2];
    logic [9:0]        s_asid  [2];
    logic [IDX_W+26:0] s_res   [2];
    logic              hit_any [2];
    logic [IDX_W-1:0]  hit_idx [2];

    assign s_vppn[0]  = s0_vppn;
    assign s_vppn[1]  = s1_vppn;
    assign s_bit12[0] = s0_va_bit12;
    assign s_bit12[1] = s1_va_bit12;
    assign s_asid[0]  = s0_asid;
    assign s_asid[1]  = s1_asid;
    assign s0_result  = s_res[0];
    assign s1_result  = s_res[1];

    // Scanning downward lets the lowest hitting index win on a multi-hit.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            hit_any[p] = 1'b0;
            hit_idx[p] = '0;
            s_res[p]   = '0;
            for (int i = TLBNUM - 1; i >= 0; i--) begin
                if (e_q[i] && (vppn_q[i] == s_vppn[p]) &&
                    (g_q[i] || (asid_q[i] == s_asid[p]))) begin
                    hit_any[p] = 1'b1;
                    hit_idx[p] = IDX_W'(i);
                end
            end
            if (hit_any[p]) begin
                if (s_bit12[p]) begin
                    s_res[p] = {1'b1, hit_idx[p], ppn1_q[hit_idx[p]], mat1_q[hit_idx[p]],
                                plv1_q[hit_idx[p]], d1_q[hit_idx[p]], v1_q[hit_idx[p]]};
                end else begin
                    s_res[p] = {1'b1, hit_idx[p], ppn0_q[hit_idx[p]], mat0_q[hit_idx[p]],
                                plv0_q[hit_idx[p]], d0_q[hit_idx[p]], v0_q[hit_idx[p]]};
                end
            end
        end
    end

    assign r_e    = e_q[r_index];
    assign r_vppn = vppn_q[r_index];
    assign r_asid = asid_q[r_index];
    assign r_g    = g_q[r_index];
    assign r_ppn0 = ppn0_q[r_index];
    assign r_plv0 = plv0_q[r_index];
    assign r_mat0 = mat0_q[r_index];
    assign r_d0   = d0_q[r_index];
    assign r_v0   = v0_q[r_index];
    assign r_ppn1 = ppn1_q[r_index];
    assign r_plv1 = plv1_q[r_index];
    assign r_mat1 = mat1_q[r_index];
    assign r_d1   = d1_q[r_index];
    assign r_v1   = v1_q[r_index];

    assign fill_index = fill_q;

    // INVTLB match rule for the entry currently under the sweep pointer
    always_comb begin
        sweep_match = 1'b0;
        unique case (op_q)
            3'd0, 3'd1: sweep_match = 1'b1;
            3'd2:       sweep_match = g_q[ptr_q];
            3'd3:       sweep_match = !g_q[ptr_q];
            3'd4:       sweep_match = !g_q[ptr_q] && (asid_q[ptr_q] == op_asid_q);
            3'd5:       sweep_match = !g_q[ptr_q] && (asid_q[ptr_q] == op_asid_q) &&
                                      (vppn_q[ptr_q] == op_vppn_q);
            3'd6:       sweep_match = (g_q[ptr_q] || (asid_q[ptr_q] == op_asid_q)) &&
                                      (vppn_q[ptr_q] == op_vppn_q);
            default:    sweep_match = 1'b0;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            op_q      <= '0;
            op_asid_q <= '0;
            op_vppn_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            fill_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            op_q      <= op_d;
            op_asid_q <= op_asid_d;
            op_vppn_q <= op_vppn_d;
            done_q    <= done_d;
            err_q     <= err_d;
            fill_q    <= fill_q + 1'b1;
        end
    end

    // next state
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        op_d      = op_q;
        op_asid_d = op_asid_q;
        op_vppn_d = op_vppn_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (inv_valid) begin
                    if (inv_op <= 5'd6) begin
                        state_d   = ST_SWEEP;
                        ptr_d     = '0;
                        op_d      = inv_op[2:0];
                        op_asid_d = inv_asid;
                        op_vppn_d = inv_vppn;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SWEEP: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // outputs
    always_comb begin
        busy       = (state_q == ST_SWEEP);
        inv_done   = done_q;
        inv_op_err = err_q;
        wr_en      = we && (state_q == ST_IDLE);
        sweep_clr  = (state_q == ST_SWEEP) && sweep_match;
    end

    // Writes happen only in IDLE and clears only in SWEEP, so a write
    // accepted alongside an INVTLB lands before the sweep visits that entry.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < TLBNUM; i++) begin
                e_q[i]    <= 1'b0;
                vppn_q[i] <= '0;
                asid_q[i] <= '0;
                g_q[i]    <= 1'b0;
                ppn0_q[i] <= '0;
                plv0_q[i] <= '0;
                mat0_q[i] <= '0;
                d0_q[i]   <= 1'b0;
                v0_q[i]   <= 1'b0;
                ppn1_q[i] <= '0;
                plv1_q[i] <= '0;
                mat1_q[i] <= '0;
                d1_q[i]   <= 1'b0;
                v1_q[i]   <= 1'b0;
            end
        end else begin
            if (wr_en) begin
                e_q[w_index]    <= w_e;
                vppn_q[w_index] <= w_vppn;
                asid_q[w_index] <= w_asid;
                g_q[w_index]    <= w_g;
                ppn0_q[w_index] <= w_ppn0;
                plv0_q[w_index] <= w_plv0;
                mat0_q[w_index] <= w_mat0;
                d0_q[w_index]   <= w_d0;
                v0_q[w_index]   <= w_v0;
                ppn1_q[w_index] <= w_ppn1;
                plv1_q[w_index] <= w_plv1;
                mat1_q[w_index] <= w_mat1;
                d1_q[w_index]   <= w_d1;
                v1_q[w_index]   <= w_v1;
            end
            if (sweep_clr) begin
                e_q[ptr_q] <= 1'b0;
            end
        end
    end

    // The pipeline stalls on busy, so a write during a sweep is a bug upstream.
    a_no_write_while_busy: assert property (@(posedge clk) disable iff (!resetn)
        !(we && (state_q == ST_SWEEP)));

endmodule

// File: tb/tb_tlb_unit.sv
module tb_tlb_unit;

    localparam int N  = 16;
    localparam int RW = 31;

    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [9:0]  asid;
        logic        g;
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } ent_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [18:0]   s0_vppn, s1_vppn;
    logic          s0_va_bit12, s1_va_bit12;
    logic [9:0]    s0_asid, s1_asid;
    logic [RW-1:0] s0_result, s1_result;
    logic          we;
    logic [3:0]    w_index, r_index;
    ent_t          wr;
    logic          r_e, r_g, r_d0, r_v0, r_d1, r_v1;
    logic [18:0]   r_vppn;
    logic [9:0]    r_asid;
    logic [19:0]   r_ppn0, r_ppn1;
    logic [1:0]    r_plv0, r_mat0, r_plv1, r_mat1;
    logic [3:0]    fill_index;
    logic          inv_valid;
    logic [4:0]    inv_op;
    logic [9:0]    inv_asid;
    logic [18:0]   inv_vppn;
    logic          busy, inv_done, inv_op_err;

    ent_t          m [N];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [RW-1:0] sb_q [$];
    int            lat_q [$];
    int            fill_q [$];

    always #5 clk = ~clk;

    tlb_unit #(.TLBNUM(N)) dut (
        .clk(clk), .resetn(resetn),
        .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid), .s0_result(s0_result),
        .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid), .s1_result(s1_result),
        .we(we), .w_index(w_index), .w_e(wr.e), .w_vppn(wr.vppn), .w_asid(wr.asid), .w_g(wr.g),
        .w_ppn0(wr.ppn0), .w_plv0(wr.plv0), .w_mat0(wr.mat0), .w_d0(wr.d0), .w_v0(wr.v0),
        .w_ppn1(wr.ppn1), .w_plv1(wr.plv1), .w_mat1(wr.mat1), .w_d1(wr.d1), .w_v1(wr.v1),
        .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_asid(r_asid), .r_g(r_g),
        .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
        .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1),
        .fill_index(fill_index),
        .inv_valid(inv_valid), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
        .busy(busy), .inv_done(inv_done), .inv_op_err(inv_op_err)
    );

    // reference search: lowest matching index, page chosen by bit 12
    function automatic logic [RW-1:0] model_search(input logic [18:0] vppn, input logic b12,
                                                    input logic [9:0] asid);
        for (int i = 0; i < N; i++) begin
            if (m[i].e && m[i].vppn == vppn && (m[i].g || m[i].asid == asid)) begin
                if (b12) return {1'b1, 4'(i), m[i].ppn1, m[i].mat1, m[i].plv1, m[i].d1, m[i].v1};
                else     return {1'b1, 4'(i), m[i].ppn0, m[i].mat0, m[i].plv0, m[i].d0, m[i].v0};
            end
        end
        return '0;
    endfunction

    function automatic bit inv_hit(input logic [4:0] op, input logic [9:0] asid,
                                   input logic [18:0] vppn, input ent_t x);
        bit gg, aa, vv;
        gg = x.g;
        aa = (x.asid == asid);
        vv = (x.vppn == vppn);
        case (op)
            5'd0, 5'd1: return 1'b1;
            5'd2:       return gg;
            5'd3:       return !gg;
            5'd4:       return !gg && aa;
            5'd5:       return !gg && aa && vv;
            5'd6:       return (gg || aa) && vv;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic idle_inputs();
        s0_vppn = '0; s0_va_bit12 = 1'b0; s0_asid = '0;
        s1_vppn = '0; s1_va_bit12 = 1'b0; s1_asid = '0;
        we = 1'b0; w_index = '0; wr = '0; r_index = '0;
        inv_valid = 1'b0; inv_op = '0; inv_asid = '0; inv_vppn = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < N; i++) m[i] = '0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic write_entry(input int idx, input ent_t ent);
        @(negedge clk);
        we = 1'b1; w_index = 4'(idx); wr = ent;
        @(posedge clk);
        m[idx] = ent;
        #1 we = 1'b0;
    endtask

    task automatic search_pair(input logic [18:0] v0, input logic b0, input logic [9:0] a0,
                               input logic [18:0] v1, input logic b1, input logic [9:0] a1);
        logic [RW-1:0] exp;
        @(negedge clk);
        s0_vppn = v0; s0_va_bit12 = b0; s0_asid = a0;
        s1_vppn = v1; s1_va_bit12 = b1; s1_asid = a1;
        sb_q.push_back(model_search(v0, b0, a0));
        sb_q.push_back(model_search(v1, b1, a1));
        #1;
        exp = sb_q.pop_front();
        n_cmp++;
        if (s0_result !== exp) begin
            n_err++;
            $display("FAIL search_p0 vppn=%h b12=%0d asid=%h: got %h expected %h", v0, b0, a0, s0_result, exp);
        end
        exp = sb_q.pop_front();
        n_cmp++;
        if (s1_result !== exp) begin
            n_err++;
            $display("FAIL search_p1 vppn=%h b12=%0d asid=%h: got %h expected %h", v1, b1, a1, s1_result, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++)
            search_pair(m[i].vppn, 1'(i), m[i].asid, m[N-1-i].vppn, !1'(i), m[N-1-i].asid);
    endtask

    task automatic check_reads();
        ent_t got;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            r_index = 4'(i);
            #1;
            got = {r_e, r_vppn, r_asid, r_g, r_ppn0, r_plv0, r_mat0, r_d0, r_v0,
                   r_ppn1, r_plv1, r_mat1, r_d1, r_v1};
            n_cmp++;
            if (got !== m[i]) begin
                n_err++;
                $display("FAIL read_entry %0d: got %h expected %h", i, got, m[i]);
            end
        end
    endtask

    function automatic ent_t rand_ent();
        ent_t x;
        x      = '0;
        x.e    = ($urandom_range(0, 3) != 0);
        x.vppn = 19'h10 + 19'($urandom_range(0, 2));
        x.asid = $urandom_range(0, 1) ? 10'd5 : 10'd6;
        x.g    = 1'($urandom_range(0, 1));
        x.ppn0 = 20'($urandom); x.plv0 = 2'($urandom); x.mat0 = 2'($urandom);
        x.d0   = 1'($urandom);  x.v0   = 1'($urandom);
        x.ppn1 = 20'($urandom); x.plv1 = 2'($urandom); x.mat1 = 2'($urandom);
        x.d1   = 1'($urandom);  x.v1   = 1'($urandom);
        return x;
    endfunction

    task automatic run_inv(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn,
                           input bit wr_en, input int widx, input ent_t went);
        int cnt;
        int exp;
        bit seen;
        @(negedge clk);
        inv_valid = 1'b1; inv_op = op; inv_asid = asid; inv_vppn = vppn;
        if (wr_en) begin
            we = 1'b1; w_index = 4'(widx); wr = went;
        end
        @(posedge clk);
        #1;
        inv_valid = 1'b0; we = 1'b0;
        if (wr_en) m[widx] = went;
        if (op <= 5'd6) begin
            for (int i = 0; i < N; i++)
                if (inv_hit(op, asid, vppn, m[i])) m[i].e = 1'b0;
            lat_q.push_back(N);
            cnt = 0;
            seen = 1'b0;
            for (int k = 0; k < 4 * N && !seen; k++) begin
                if (busy) cnt++;
                @(posedge clk);
                #1;
                if (inv_done) seen = 1'b1;
            end
            exp = lat_q.pop_front();
            n_cmp++;
            if (!seen || cnt != exp) begin
                n_err++;
                $display("FAIL inv_latency op=%0d: busy cycles %0d done_seen %0d, expected %0d cycles and done", op, cnt, seen, exp);
            end
            n_cmp++;
            if (busy !== 1'b0) begin
                n_err++;
                $display("FAIL inv_busy_end op=%0d: got %b expected 0", op, busy);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (inv_done !== 1'b0) begin
                n_err++;
                $display("FAIL inv_done_pulse op=%0d: got %b expected 0", op, inv_done);
            end
        end else begin
            n_cmp++;
            if (inv_op_err !== 1'b1 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL inv_op_err op=%0d: err=%b busy=%b expected err=1 busy=0", op, inv_op_err, busy);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (inv_op_err !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL inv_op_err_pulse: err=%b busy=%b expected 0 0", inv_op_err, busy);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({busy, inv_done, inv_op_err} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 000", {busy, inv_done, inv_op_err});
        end
        check_reads();
        search_pair('0, 1'b0, '0, '0, 1'b1, '0);
    endtask

    task automatic test_fill_index();
        int exp;
        do_reset();
        for (int k = 1; k <= 20; k++) fill_q.push_back(k % N);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            exp = fill_q.pop_front();
            n_cmp++;
            if (fill_index !== 4'(exp)) begin
                n_err++;
                $display("FAIL fill_index step %0d: got %0d expected %0d", k, fill_index, exp);
            end
        end
    endtask

    task automatic test_search_basic();
        ent_t e3;
        logic [RW-1:0] want;
        do_reset();
        e3 = '0;
        e3.e = 1'b1; e3.vppn = 19'h12345; e3.asid = 10'd5; e3.ppn0 = 20'hAAAAA; e3.v0 = 1'b1;
        e3.ppn1 = 20'hBBBBB; e3.d1 = 1'b1;
        @(negedge clk);
        we = 1'b1; w_index = 4'd3; wr = e3;
        s0_vppn = 19'h12345; s0_va_bit12 = 1'b1; s0_asid = 10'd5;
        #1;
        n_cmp++;
        if (s0_result !== '0) begin
            n_err++;
            $display("FAIL write_not_yet_visible: got %h expected 0", s0_result);
        end
        @(posedge clk);
        m[3] = e3;
        #1 we = 1'b0;
        want = {1'b1, 4'd3, 20'hBBBBB, 2'd0, 2'd0, 1'b1, 1'b0};
        n_cmp++;
        if (s0_result !== want) begin
            n_err++;
            $display("FAIL write_visible_odd: got %h expected %h", s0_result, want);
        end
        search_pair(19'h12345, 1'b1, 10'd6, 19'h12345, 1'b0, 10'd5);
        want = {1'b1, 4'd3, 20'hAAAAA, 2'd0, 2'd0, 1'b0, 1'b1};
        n_cmp++;
        if (s0_result !== '0 || s1_result !== want) begin
            n_err++;
            $display("FAIL asid_miss_even_hit: got %h/%h expected 0/%h", s0_result, s1_result, want);
        end
    endtask

    task automatic test_multi_hit();
        ent_t e7;
        e7 = '0;
        e7.e = 1'b1; e7.vppn = 19'h12345; e7.asid = 10'd9; e7.g = 1'b1;
        e7.ppn1 = 20'h77777; e7.v1 = 1'b1; e7.plv1 = 2'd3; e7.mat1 = 2'd1;
        write_entry(7, e7);
        search_pair(19'h12345, 1'b1, 10'd5, 19'h12345, 1'b1, 10'd6);
        n_cmp++;
        if (s0_result[29:26] !== 4'd3 || s1_result[29:26] !== 4'd7) begin
            n_err++;
            $display("FAIL multi_hit_index: got %0d/%0d expected 3/7", s0_result[29:26], s1_result[29:26]);
        end
        @(negedge clk);
        r_index = 4'd7;
        #1;
        n_cmp++;
        if (r_g !== 1'b1 || r_e !== 1'b1) begin
            n_err++;
            $display("FAIL read_g_idx7: got g=%b e=%b expected 1 1", r_g, r_e);
        end
    endtask

    task automatic test_inv_op3();
        ent_t x;
        do_reset();
        for (int i = 0; i < N; i++) begin
            x = '0;
            x.e = 1'b1; x.g = 1'(i); x.asid = 10'd5; x.vppn = 19'h200 + 19'(i);
            x.ppn0 = 20'(i); x.v0 = 1'b1;
            write_entry(i, x);
        end
        run_inv(5'd3, 10'd0, 19'd0, 1'b0, 0, '0);
        for (int i = 0; i < N; i++) begin
            search_pair(19'h200 + 19'(i), 1'b0, 10'd5, 19'h200 + 19'(i), 1'b1, 10'd7);
            n_cmp++;
            if (s0_result[30] !== 1'(i)) begin
                n_err++;
                $display("FAIL op3_survivor %0d: found %b expected %b", i, s0_result[30], 1'(i));
            end
        end
    endtask

    task automatic test_inv_op5_err();
        ent_t x;
        do_reset();
        for (int i = 0; i < N; i++) begin
            x = '0;
            x.e = 1'b1; x.asid = 10'd5; x.vppn = 19'h400 + 19'(i); x.ppn1 = 20'h100 + 20'(i);
            write_entry(i, x);
        end
        run_inv(5'd5, 10'd5, 19'h403, 1'b0, 0, '0);
        check_reads();
        @(negedge clk);
        r_index = 4'd3;
        #1;
        n_cmp++;
        if (r_e !== 1'b0) begin
            n_err++;
            $display("FAIL op5_entry3_cleared: got e=%b expected 0", r_e);
        end
        run_inv(5'd7, 10'd5, 19'h404, 1'b0, 0, '0);
        check_reads();
    endtask

    task automatic test_inv_with_write();
        ent_t x;
        do_reset();
        for (int i = 0; i < N; i++) write_entry(i, rand_ent());
        x = rand_ent();
        x.e = 1'b1; x.g = 1'b0; x.vppn = 19'h300;
        run_inv(5'd3, 10'd0, 19'd0, 1'b1, 1, x);
        check_reads();
        x.g = 1'b1; x.vppn = 19'h301;
        run_inv(5'd5, 10'd5, 19'h301, 1'b1, 2, x);
        check_reads();
        check_all();
    endtask

    task automatic test_inv_all_ops();
        for (int op = 0; op <= 6; op++) begin
            for (int i = 0; i < N; i++) write_entry(i, rand_ent());
            run_inv(5'(op), 10'd5, 19'h11, 1'b0, 0, '0);
            check_all();
            check_reads();
        end
    endtask

    task automatic test_reset_mid_sweep();
        ent_t x;
        bit done_seen;
        for (int i = 0; i < N; i++) begin
            x = rand_ent();
            x.e = 1'b1;
            write_entry(i, x);
        end
        @(negedge clk);
        inv_valid = 1'b1; inv_op = 5'd0;
        @(posedge clk);
        #1 inv_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) m[i] = '0;
        n_cmp++;
        if (busy !== 1'b0 || inv_done !== 1'b0 || fill_index !== 4'd0) begin
            n_err++;
            $display("FAIL reset_mid_sweep: busy=%b done=%b fill=%0d expected 0 0 0", busy, inv_done, fill_index);
        end
        @(negedge clk);
        resetn = 1'b1;
        done_seen = 1'b0;
        for (int k = 0; k < 2 * N; k++) begin
            @(posedge clk);
            #1;
            if (inv_done || busy) done_seen = 1'b1;
        end
        n_cmp++;
        if (done_seen) begin
            n_err++;
            $display("FAIL reset_aborts_sweep: got done/busy activity expected none");
        end
        check_reads();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fill_index();
        test_search_basic();
        test_multi_hit();
        test_inv_op3();
        test_inv_op5_err();
        test_inv_with_write();
        test_inv_all_ops();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
